// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Registered request/ready handshake with an optional per-transaction timeout.
module mem_arbiter #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_ack,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic             d_ack,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_err,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_value,
  input  logic             mem_ready,
  output logic             busy
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ptr, w_ptr_nxt;          // 1: data port has priority on a tie
  logic             r_sel_d, w_sel_d_nxt;      // 1: data port owns the current transaction
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_grant_d;
  logic             w_timeout;
  logic [WIDTH-1:0] w_addr_nxt, w_wdata_nxt, w_if_rdata_nxt, w_d_rdata_nxt;
  logic             w_rd_nxt, w_wr_nxt, w_busy_nxt;
  logic             w_if_ack_nxt, w_if_err_nxt, w_d_ack_nxt, w_d_err_nxt;

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_sel_d_nxt    = r_sel_d;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = mem_address;
    w_wdata_nxt    = mem_wdata;
    w_rd_nxt       = mem_read;
    w_wr_nxt       = mem_write;
    w_if_rdata_nxt = if_rdata;
    w_d_rdata_nxt  = d_rdata;
    w_if_ack_nxt   = 1'b0;
    w_if_err_nxt   = 1'b0;
    w_d_ack_nxt    = 1'b0;
    w_d_err_nxt    = 1'b0;
    w_grant_d      = d_req && (!if_req || r_ptr);
    w_timeout      = (TIMEOUT != 0) && (r_cnt == LP_CNT_LAST);

    case (r_state)
      ST_IDLE: begin
        if (if_req || d_req) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = '0;
          w_sel_d_nxt = w_grant_d;
          if (w_grant_d) begin
            w_addr_nxt  = d_addr;
            w_wdata_nxt = d_wdata;
            w_rd_nxt    = !d_we;
            w_wr_nxt    = d_we;
          end else begin
            w_addr_nxt  = if_addr;
            w_rd_nxt    = 1'b1;
            w_wr_nxt    = 1'b0;
          end
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt + 1'b1;
        // mem_ready wins over a coincident timeout
        if (mem_ready || w_timeout) begin
          w_state_nxt = ST_DONE;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
          w_ptr_nxt   = !r_sel_d;
          if (r_sel_d) begin
            w_d_ack_nxt = 1'b1;
            w_d_err_nxt = !mem_ready;
            if (mem_ready && !mem_write) w_d_rdata_nxt = mem_value;
          end else begin
            w_if_ack_nxt = 1'b1;
            w_if_err_nxt = !mem_ready;
            if (mem_ready) w_if_rdata_nxt = mem_value;
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= 1'b0;
      r_sel_d     <= 1'b0;
      r_cnt       <= '0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      if_ack      <= 1'b0;
      if_err      <= 1'b0;
      if_rdata    <= '0;
      d_ack       <= 1'b0;
      d_err       <= 1'b0;
      d_rdata     <= '0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel_d     <= w_sel_d_nxt;
      r_cnt       <= w_cnt_nxt;
      mem_address <= w_addr_nxt;
      mem_wdata   <= w_wdata_nxt;
      mem_read    <= w_rd_nxt;
      mem_write   <= w_wr_nxt;
      if_ack      <= w_if_ack_nxt;
      if_err      <= w_if_err_nxt;
      if_rdata    <= w_if_rdata_nxt;
      d_ack       <= w_d_ack_nxt;
      d_err       <= w_d_err_nxt;
      d_rdata     <= w_d_rdata_nxt;
      busy        <= w_busy_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, write, round-robin, timeout, async reset, spurious ready.
module tb_mem_arbiter;
  localparam int WIDTH = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [WIDTH-1:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_value = '0;
  logic             if_ack, if_err, d_ack, d_err, mem_read, mem_write, busy;
  logic [WIDTH-1:0] if_rdata, d_rdata, mem_address, mem_wdata;

  int tests = 0;
  int fails = 0;
  int n_wr = 0, n_ifack = 0, n_dack = 0, n_sovl = 0, n_aovl = 0;

  mem_arbiter #(.WIDTH(WIDTH), .TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_value(mem_value), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (mem_write) n_wr++;
    if (if_ack) n_ifack++;
    if (d_ack) n_dack++;
    if (mem_read && mem_write) n_sovl++;
    if (if_ack && d_ack) n_aovl++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) tick();
    tests++;
    if ({busy, mem_read, mem_write, if_ack, d_ack, if_err, d_err} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 0000000", {busy, mem_read, mem_write, if_ack, d_ack, if_err, d_err});
    end
    tests++;
    if ({mem_address, mem_wdata, if_rdata, d_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_data: got %h want 0", {mem_address, mem_wdata, if_rdata, d_rdata});
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    int rd_cnt, wr0, ack0;
    wr0 = n_wr; ack0 = n_ifack; rd_cnt = 0;
    if_addr = 16'h0004; if_req = 1'b1;
    tick();
    tests++;
    if (mem_address !== 16'h0004) begin
      fails++; $display("FAIL fetch_addr: got %h want 0004", mem_address);
    end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL fetch_busy: got %b want 1", busy); end
    rd_cnt += int'(mem_read);
    tick(); rd_cnt += int'(mem_read);
    tick(); rd_cnt += int'(mem_read);
    mem_value = 16'h1234; mem_ready = 1'b1;
    tick(); rd_cnt += int'(mem_read);
    tests++;
    if (rd_cnt !== 3) begin fails++; $display("FAIL fetch_rd_len: got %0d want 3", rd_cnt); end
    tests++;
    if ({if_ack, if_err, if_rdata} !== {1'b1, 1'b0, 16'h1234}) begin
      fails++; $display("FAIL fetch_ack: got ack=%b err=%b rdata=%h want 1 0 1234", if_ack, if_err, if_rdata);
    end
    mem_ready = 1'b0; if_req = 1'b0;
    tick();
    tests++;
    if ({if_ack, busy, if_rdata} !== {1'b0, 1'b0, 16'h1234}) begin
      fails++; $display("FAIL fetch_after: got ack=%b busy=%b rdata=%h want 0 0 1234", if_ack, busy, if_rdata);
    end
    tests++;
    if ((n_ifack - ack0) !== 1) begin fails++; $display("FAIL fetch_ack_cnt: got %0d want 1", n_ifack - ack0); end
    tests++;
    if ((n_wr - wr0) !== 0) begin fails++; $display("FAIL fetch_no_write: got %0d want 0", n_wr - wr0); end
  endtask

  task automatic test_write();
    d_addr = 16'h0010; d_wdata = 16'hBEEF; d_we = 1'b1; d_req = 1'b1;
    tick();
    tests++;
    if ({mem_write, mem_read, mem_address, mem_wdata} !== {1'b1, 1'b0, 16'h0010, 16'hBEEF}) begin
      fails++; $display("FAIL wr_issue: got wr=%b rd=%b a=%h d=%h want 1 0 0010 beef", mem_write, mem_read, mem_address, mem_wdata);
    end
    tick(); tick();
    tests++;
    if ({mem_write, mem_wdata} !== {1'b1, 16'hBEEF}) begin
      fails++; $display("FAIL wr_hold: got wr=%b d=%h want 1 beef", mem_write, mem_wdata);
    end
    mem_value = 16'h5555; mem_ready = 1'b1;
    tick();
    tests++;
    if ({mem_write, d_ack, d_err, d_rdata} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      fails++; $display("FAIL wr_ack: got wr=%b ack=%b err=%b rdata=%h want 0 1 0 0000", mem_write, d_ack, d_err, d_rdata);
    end
    mem_ready = 1'b0; d_req = 1'b0; d_we = 1'b0;
    tick();
    tests++;
    if ({d_ack, busy} !== 2'b00) begin fails++; $display("FAIL wr_done: got ack=%b busy=%b want 0 0", d_ack, busy); end
  endtask

  task automatic test_round_robin();
    int k;
    logic exp_d;
    do_reset();
    if_addr = 16'h0100; d_addr = 16'h0200; d_we = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2) == 1;
      k = 0;
      while (mem_read !== 1'b1 && k < 6) begin tick(); k++; end
      tests++;
      if (mem_read !== 1'b1) begin fails++; $display("FAIL rr_strobe[%0d]: got %b want 1", t, mem_read); end
      tests++;
      if (mem_address !== (exp_d ? 16'h0200 : 16'h0100)) begin
        fails++; $display("FAIL rr_grant[%0d]: got %h want %h", t, mem_address, exp_d ? 16'h0200 : 16'h0100);
      end
      if (t > 0) begin
        tests++;
        if (k !== 2) begin fails++; $display("FAIL rr_turnaround[%0d]: got %0d want 2", t, k); end
      end
      mem_value = 16'hA000 + 16'(t); mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      tests++;
      if ({if_ack, d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL rr_ack[%0d]: got %b want %b", t, {if_ack, d_ack}, exp_d ? 2'b01 : 2'b10);
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    tests++;
    if ({if_rdata, d_rdata} !== {16'hA002, 16'hA003}) begin
      fails++; $display("FAIL rr_rdata: got %h %h want a002 a003", if_rdata, d_rdata);
    end
  endtask

  task automatic test_timeout();
    int rd_cnt;
    d_addr = 16'h0020; d_we = 1'b0; d_req = 1'b1;
    tick();
    tests++;
    if ({mem_read, mem_address} !== {1'b1, 16'h0020}) begin
      fails++; $display("FAIL to_issue: got rd=%b a=%h want 1 0020", mem_read, mem_address);
    end
    if_addr = 16'h0030; if_req = 1'b1;
    rd_cnt = 1;
    for (int i = 0; i < 20 && mem_read === 1'b1; i++) begin
      tick();
      if (mem_read === 1'b1) rd_cnt++;
    end
    tests++;
    if (rd_cnt !== 16) begin fails++; $display("FAIL to_len: got %0d want 16", rd_cnt); end
    tests++;
    if ({d_ack, d_err, if_ack, d_rdata} !== {1'b1, 1'b1, 1'b0, 16'hA003}) begin
      fails++; $display("FAIL to_ack: got ack=%b err=%b if_ack=%b rdata=%h want 1 1 0 a003", d_ack, d_err, if_ack, d_rdata);
    end
    d_req = 1'b0;
    tick(); tick();
    tests++;
    if ({mem_read, mem_address} !== {1'b1, 16'h0030}) begin
      fails++; $display("FAIL to_next: got rd=%b a=%h want 1 0030", mem_read, mem_address);
    end
    mem_value = 16'h7777; mem_ready = 1'b1;
    tick();
    tests++;
    if ({if_ack, if_err, if_rdata} !== {1'b1, 1'b0, 16'h7777}) begin
      fails++; $display("FAIL to_next_ack: got ack=%b err=%b rdata=%h want 1 0 7777", if_ack, if_err, if_rdata);
    end
    mem_ready = 1'b0; if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_wait();
    int ack0;
    if_addr = 16'h0044; if_req = 1'b1;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({mem_read, busy, if_ack} !== 3'b000) begin
      fails++; $display("FAIL rst_async: got rd=%b busy=%b ack=%b want 0 0 0", mem_read, busy, if_ack);
    end
    tests++;
    if ({mem_address, if_rdata} !== 32'h0) begin
      fails++; $display("FAIL rst_async_data: got %h want 0", {mem_address, if_rdata});
    end
    tick();
    reset_n = 1'b1;
    ack0 = n_ifack;
    tick();
    tests++;
    if ({mem_read, mem_address} !== {1'b1, 16'h0044}) begin
      fails++; $display("FAIL rst_refetch: got rd=%b a=%h want 1 0044", mem_read, mem_address);
    end
    mem_value = 16'h4444; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0; if_req = 1'b0;
    tick(); tick();
    tests++;
    if ((n_ifack - ack0) !== 1 || if_rdata !== 16'h4444) begin
      fails++; $display("FAIL rst_refetch_ack: got acks=%0d rdata=%h want 1 4444", n_ifack - ack0, if_rdata);
    end
  endtask

  task automatic test_spurious_ready();
    int ack0, dack0;
    ack0 = n_ifack; dack0 = n_dack;
    mem_value = 16'hDEAD; mem_ready = 1'b1;
    tick(); tick();
    tests++;
    if ({busy, mem_read, if_ack, d_ack, if_rdata, d_rdata} !== {4'b0000, 16'h4444, 16'h0000}) begin
      fails++; $display("FAIL sp_idle: got busy=%b rd=%b acks=%b%b rdata=%h %h want 0 0 00 4444 0000", busy, mem_read, if_ack, d_ack, if_rdata, d_rdata);
    end
    mem_ready = 1'b0;
    if_addr = 16'h0050; if_req = 1'b1;
    tick();
    mem_value = 16'h1111; mem_ready = 1'b1;
    tick();
    tests++;
    if ({if_ack, if_rdata} !== {1'b1, 16'h1111}) begin
      fails++; $display("FAIL sp_ack: got ack=%b rdata=%h want 1 1111", if_ack, if_rdata);
    end
    if_req = 1'b0; mem_value = 16'hDEAD;
    tick(); tick();
    mem_ready = 1'b0;
    tests++;
    if ({busy, mem_read, if_ack, if_rdata} !== {3'b000, 16'h1111}) begin
      fails++; $display("FAIL sp_done: got busy=%b rd=%b ack=%b rdata=%h want 0 0 0 1111", busy, mem_read, if_ack, if_rdata);
    end
    tests++;
    if ((n_ifack - ack0) !== 1 || (n_dack - dack0) !== 0) begin
      fails++; $display("FAIL sp_ack_cnt: got if=%0d d=%0d want 1 0", n_ifack - ack0, n_dack - dack0);
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (n_sovl !== 0) begin fails++; $display("FAIL strobe_overlap: got %0d want 0", n_sovl); end
    tests++;
    if (n_aovl !== 0) begin fails++; $display("FAIL ack_overlap: got %0d want 0", n_aovl); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write();
    test_round_robin();
    test_timeout();
    test_reset_mid_wait();
    test_spurious_ready();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, limit 100000", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between the CPU instruction-fetch path and the CPU load/store path.
- Uses round-robin priority, a registered request/ready handshake on the memory side, and a per-transaction timeout.
- Sits between the CPU core and the memory model, and replaces direct core-to-memory wiring of mem_address, mem_read and mem_ready.

Parameters:
- WIDTH, 16, address and data width in bits.
- TIMEOUT, 16, maximum cycles spent waiting for mem_ready before aborting. 0 disables the timeout.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  WIDTH  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle completion pulse for the fetch port.
- if_rdata  out  WIDTH  fetched word; valid while if_ack is high, then holds its value.
- if_err  out  1  high together with if_ack when the fetch timed out.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  WIDTH  data address.
- d_wdata  in  WIDTH  write data.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  WIDTH  read data; valid while d_ack is high, then holds its value.
- d_err  out  1  high together with d_ack when the data access timed out.
- mem_address  out  WIDTH  registered memory address.
- mem_wdata  out  WIDTH  registered memory write data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_value  in  WIDTH  memory read data; sampled when mem_ready is high.
- mem_ready  in  1  memory completion; sampled synchronously, level-sensitive.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - all strobes, acks, errs and busy go to 0;
  - mem_address, mem_wdata, if_rdata and d_rdata go to 0;
  - state goes to IDLE, priority pointer goes to fetch, timeout counter goes to 0;
  - an in-flight transaction is dropped with no ack.
- States: IDLE, WAIT, DONE. All outputs are registered.
- IDLE:
  - Requests are sampled at each rising edge.
  - If exactly one port requests, it wins.
  - If both request, the port named by the priority pointer wins.
  - The winner's address is latched into mem_address. Write data and the write flag are latched only for the data port.
  - mem_read = 1, or mem_write = 1 for a data write, is asserted the cycle after the sample; state goes to WAIT and the counter clears.
  - mem_ready seen in IDLE is ignored.
- WAIT:
  - mem_address, mem_wdata and the strobe are held constant.
  - The counter increments each cycle.
  - If mem_ready is sampled high:
    - latch mem_value into the winner's rdata (reads only; writes leave rdata unchanged);
    - drop the strobe, pulse the winner's ack for the next cycle with err = 0;
    - set the priority pointer to the other port; state goes to DONE.
  - Else, if TIMEOUT != 0 and the counter reaches TIMEOUT-1:
    - drop the strobe, pulse ack with err = 1, and leave rdata unchanged;
    - update the pointer the same way; state goes to DONE.
  - mem_ready has priority over timeout when both occur in the same cycle.
- DONE:
  - Lasts one cycle: ack/err are high and strobes are low. State then goes to IDLE.
  - Requests are not sampled in DONE. A requester drops req on the edge at which it sees ack.
  - A request still high in the following IDLE is treated as a new transaction.
- Latency:
  - Request sampled at edge N gives strobe high from N+1.
  - mem_ready sampled at edge M gives ack high from M+1 to M+2.
  - The earliest next strobe is M+3.
  - Minimum turnaround with zero memory wait is 3 cycles per access.
- mem_read and mem_write are never high together. Only one of if_ack and d_ack is high in any cycle.
- A requester that drops req while granted does not abort the transaction; ack still pulses.

Test Plan:
1. Reset, then fetch: if_req=1, if_addr=0x0004; memory returns 0x1234 with mem_ready two cycles after mem_read -> mem_address=0x0004, mem_read high for exactly 3 cycles, if_ack one pulse with if_rdata=0x1234, if_err=0, mem_write never asserted.
2. Data write: d_req=1, d_we=1, d_addr=0x0010, d_wdata=0xBEEF -> mem_write=1, mem_wdata=0xBEEF held until mem_ready, d_ack pulses, d_rdata unchanged (0).
3. Both ports request continuously for 4 transactions after reset -> grant order fetch, data, fetch, data; acks are never simultaneous; strobes are never overlapping.
4. Timeout: TIMEOUT=16, mem_ready tied 0, d_req read at 0x0020 -> mem_read high 16 cycles then low, d_ack and d_err pulse together, d_rdata unchanged; next IDLE serves a pending if_req normally.
5. Reset mid-WAIT: assert reset_n=0 two cycles into a fetch -> mem_read, busy and if_ack go 0 asynchronously; after release with if_req still high, a fresh fetch is issued and acked once.
6. Spurious mem_ready pulse in IDLE and in DONE -> no ack, no rdata change, no state change.
